// File: rtl/fir_pkg.sv
// Shared widths and coefficient set for the systolic FIR filter.
package fir_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned COEF_W = 16;
  localparam int unsigned TAPS   = 8;
  localparam int unsigned OUT_W  = DATA_W + COEF_W + $clog2(TAPS);

  // Symmetric low-pass kernel, DC gain 20.
  localparam logic signed [COEF_W-1:0] COEFS [TAPS] = '{
    16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd4, 16'sd3, 16'sd2, 16'sd1
  };

endpackage : fir_pkg

// File: rtl/systolic_fir_filter_if.sv
// Sample stream into the filter and filtered stream out of it.
interface systolic_fir_filter_if;
  import fir_pkg::*;

  logic signed [DATA_W-1:0] original;
  logic signed [OUT_W-1:0]  filtered;

  // Source/consumer side.
  modport master (output original, input filtered);
  // Filter side.
  modport slave  (input original, output filtered);

endinterface : systolic_fir_filter_if

// File: rtl/fir_pe.sv
// One multiply-accumulate stage of the transposed-form FIR chain.
module fir_pe
  import fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [OUT_W-1:0]  sum_in,
  output logic signed [OUT_W-1:0]  sum_out
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [OUT_W-1:0]  sum_d;
  logic signed [OUT_W-1:0]  sum_q;

  // Full-precision product, sign-extended before joining the partial sum.
  always_comb begin
    prod_c = x * coef;
    sum_d  = OUT_W'(prod_c) + sum_in;
  end

  // Partial-sum register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_out = sum_q;

endmodule : fir_pe

// File: rtl/systolic_fir_filter.sv
// Streaming TAPS-tap FIR: registered input broadcast to a PE chain whose
// partial sums shift toward PE0; PE0's sum register is the output.
module systolic_fir_filter
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  systolic_fir_filter_if.slave fir
);

  logic signed [DATA_W-1:0] x_d;
  logic signed [DATA_W-1:0] x_q;
  logic signed [OUT_W-1:0]  sum_w [TAPS+1];

  assign x_d         = fir.original;
  assign sum_w[TAPS] = '0;

  // Input sample register feeding every PE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
    end else begin
      x_q <= x_d;
    end
  end

  // PE k adds h[k]*x to the partial sum arriving from PE k+1.
  for (genvar k = 0; k < TAPS; k++) begin : g_pe
    fir_pe u_pe (
      .clk     (clk),
      .rst     (rst),
      .x       (x_q),
      .coef    (COEFS[k]),
      .sum_in  (sum_w[k+1]),
      .sum_out (sum_w[k])
    );
  end

  assign fir.filtered = sum_w[0];

endmodule : systolic_fir_filter

// File: tb/tb_systolic_fir_filter.sv
// Scoreboard bench: the driver queues the expected output for every sample it
// presents; the monitor pops and compares on each falling edge.
module tb_systolic_fir_filter;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_fir_filter_if fir ();

  systolic_fir_filter dut (
    .clk (clk),
    .rst (rst),
    .fir (fir)
  );

  localparam longint H    [8]  = '{1, 2, 3, 4, 4, 3, 2, 1};
  localparam longint IMP  [10] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0};
  localparam longint RAMP [10] = '{1, 3, 6, 10, 14, 17, 19, 20, 20, 20};

  longint hist [8];
  longint exp_q [$];
  bit     mon_en = 1'b0;
  int     checks = 0;
  int     failures = 0;
  string  tag = "init";

  // Reference FIR over the captured sample history.
  function automatic longint model();
    longint acc = 0;
    for (int k = 0; k < 8; k++) acc += H[k] * hist[k];
    return acc;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: filtered=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint out_val();
    return longint'($signed(fir.filtered));
  endfunction

  // Monitor: one output per clock, compared against the oldest expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_underflow: filtered=%0d expected=<none>", tag, out_val());
      end else begin
        check(tag, out_val(), exp_q.pop_front());
      end
    end
  end

  // Present one sample for the next rising edge and queue its expected output.
  task automatic drive(input logic [DATA_W-1:0] v, input bit use_tbl, input longint e);
    fir.original = v;
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = longint'($signed(v));
    exp_q.push_back(use_tbl ? e : model());
    @(posedge clk);
    #1;
  endtask

  // Let the two outstanding outputs reach the monitor.
  task automatic drain();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Async reset with random input; output must be zero throughout.
  task automatic do_reset(input int cycles);
    mon_en = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_async", out_val(), 0);
    repeat (cycles) begin
      @(negedge clk);
      fir.original = $urandom;
      check("rst_hold", out_val(), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) hist[k] = 0;
    exp_q.push_back(0);
    exp_q.push_back(0);
    mon_en = 1'b1;
  endtask

  initial begin
    fir.original = $urandom;
    #2;
    tag = "reset";
    do_reset(1);

    tag = "impulse";
    for (int i = 0; i < 10; i++) drive((i == 0) ? 32'd1 : 32'd0, 1'b1, IMP[i]);
    drain();

    do_reset(1);
    tag = "step";
    for (int i = 0; i < 10; i++) drive(32'd1, 1'b1, RAMP[i]);
    drain();

    do_reset(1);
    tag = "min_extreme";
    for (int i = 0; i < 10; i++) drive(32'h8000_0000, 1'b1, -64'sd2147483648 * RAMP[i]);
    drain();

    do_reset(1);
    tag = "max_extreme";
    for (int i = 0; i < 10; i++) drive(32'h7FFF_FFFF, 1'b1, 64'sd2147483647 * RAMP[i]);
    drain();

    do_reset(1);
    tag = "step_pre_rst";
    for (int i = 0; i < 4; i++) drive(32'd1, 1'b1, RAMP[i]);
    tag = "midstream_rst";
    do_reset(2);
    tag = "step_post_rst";
    for (int i = 0; i < 10; i++) drive(32'd1, 1'b1, RAMP[i]);
    drain();

    do_reset(1);
    tag = "random";
    for (int i = 0; i < 100; i++) drive($urandom, 1'b0, 0);
    for (int i = 0; i < 8; i++) drive(32'd0, 1'b0, 0);
    drain();

    mon_en = 1'b0;
    check("queue_empty", longint'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_systolic_fir_filter
